// File: rtl/mult_pkg.sv
// Shared definitions for the 7x7 multiplier datapath and its BCD back end.
//   PRODUCT_W  : width of the multiplier product (7 + 7 bits)
//   BCD_DIGITS : decimal digits needed to show the largest product
//   state_e    : converter FSM encoding (IDLE=00, SHIFT=01, DONE=10)
package mult_pkg;

    localparam int PRODUCT_W  = 14;
    localparam int BCD_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
//   d_i : 4-bit BCD digit before the shift
//   d_o : corrected digit
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter for the multiplier product, one bit per
// clock using shift-and-add-3. Feeds the seven-segment display driver.
//
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, taken only when ready (IDLE or DONE)
//   bin      : binary product, captured in the start cycle
//   busy     : high while iterating (SHIFT)
//   done     : one-cycle pulse, bcd freshly updated
//   bcd      : packed BCD result, digit 0 in [3:0], held between conversions
//   digit_en : per-digit display enable
//
// Handshake: a request is accepted on a rising edge where start = 1 and the
// FSM is in IDLE or DONE; any start seen while busy is dropped, not queued.
//
// Build option PRODUCT_BCD_BLANK_EN: when defined, digit_en blanks leading
// zero digits (digit 0 always lit). When undefined, digit_en is all ones.
module product_bcd_converter
    import mult_pkg::*;
#(
    parameter int IN_W   = PRODUCT_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W);

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  shreg_q, shreg_d;
    logic [BCD_W-1:0] scratch_q, scratch_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;

    logic [BCD_W-1:0] corr;
    logic [BCD_W-1:0] scratch_sh;
    logic [IN_W-1:0]  shreg_sh;
    logic             unused_carry;

    logic ready;
    logic accept;
    logic last_iter;

    assign ready     = (state_q == IDLE) || (state_q == DONE);
    assign accept    = start && ready;
    assign last_iter = (cnt_q == CNT_W'(IN_W - 1));

    // Correct every scratch digit, then shift {scratch, shreg} left by one.
    // The bit leaving the top digit is always zero for legal parameters.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i (scratch_q[4*g +: 4]),
            .d_o (corr[4*g +: 4])
        );
    end

    assign {unused_carry, scratch_sh, shreg_sh} = {corr, shreg_q, 1'b0};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_iter) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        if (accept) begin
            cnt_d     = '0;
            shreg_d   = bin;
            scratch_d = '0;
        end else if (state_q == SHIFT) begin
            cnt_d     = cnt_q + CNT_W'(1);
            shreg_d   = shreg_sh;
            scratch_d = scratch_sh;
            if (last_iter) begin
                bcd_d = scratch_sh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
        end
    end

    assign bcd = bcd_q;

`ifdef PRODUCT_BCD_BLANK_EN
    logic [DIGITS-1:0] digit_en_q, digit_en_d;
    logic [DIGITS-1:0] blank_en;

    // Digit i is lit when it or any more-significant digit is nonzero.
    always_comb begin
        logic seen;
        seen     = 1'b0;
        blank_en = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen        = seen | (|scratch_sh[4*i +: 4]);
            blank_en[i] = seen;
        end
        blank_en[0] = 1'b1;
    end

    always_comb begin
        digit_en_d = digit_en_q;
        if (state_q == SHIFT && last_iter) begin
            digit_en_d = blank_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_en_q <= '1;
        end else begin
            digit_en_q <= digit_en_d;
        end
    end

    assign digit_en = digit_en_q;
`else
    assign digit_en = '1;
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
module tb_product_bcd_converter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  digit_en;

    int checks   = 0;
    int failures = 0;

    logic [19:0] exp_q[$];

    product_bcd_converter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .digit_en (digit_en)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: decimal digit extraction (not double-dabble).
    function automatic logic [19:0] model_bcd(input int v);
        logic [19:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_en(input logic [19:0] b);
`ifdef PRODUCT_BCD_BLANK_EN
        logic [4:0] e;
        logic       seen;
        seen = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (b[4*i +: 4] != 4'd0) seen = 1'b1;
            e[i] = seen;
        end
        e[0] = 1'b1;
        return e;
`else
        return (b == 20'h0) ? 5'b11111 : 5'b11111;
`endif
    endfunction

    // Issue one request at a negedge and wait (bounded) for done.
    // lat counts negedges from the request to the done sample.
    task automatic run_conv(input logic [13:0] v, output logic [19:0] b,
                            output logic [4:0] en, output int lat);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        lat   = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            bin   = 14'($urandom_range(0, 16383));
            lat++;
        end while (!done && lat < 40);
        b  = bcd;
        en = digit_en;
    endtask

    typedef struct {
        logic [13:0] bin;
        logic [19:0] exp_bcd;
        logic [4:0]  exp_en_blank;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [19:0] got_b;
        logic [4:0]  got_en;
        int          lat;
        int          n_busy;
        int          n_done;
        logic [19:0] exp_b;

        vecs[0]  = '{14'd0,     20'h00000, 5'b00001};
        vecs[1]  = '{14'd1,     20'h00001, 5'b00001};
        vecs[2]  = '{14'd9,     20'h00009, 5'b00001};
        vecs[3]  = '{14'd10,    20'h00010, 5'b00011};
        vecs[4]  = '{14'd99,    20'h00099, 5'b00011};
        vecs[5]  = '{14'd100,   20'h00100, 5'b00111};
        vecs[6]  = '{14'd1000,  20'h01000, 5'b01111};
        vecs[7]  = '{14'd8191,  20'h08191, 5'b01111};
        vecs[8]  = '{14'd9999,  20'h09999, 5'b01111};
        vecs[9]  = '{14'd12345, 20'h12345, 5'b11111};
        vecs[10] = '{14'd16129, 20'h16129, 5'b11111};
        vecs[11] = '{14'd16383, 20'h16383, 5'b11111};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd), 32'h0);
        check("reset_en", 32'(digit_en), 32'h1f);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            run_conv(vecs[i].bin, got_b, got_en, lat);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd15);
            check($sformatf("tbl%0d_bcd", i), 32'(got_b), 32'(vecs[i].exp_bcd));
`ifdef PRODUCT_BCD_BLANK_EN
            check($sformatf("tbl%0d_en", i), 32'(got_en), 32'(vecs[i].exp_en_blank));
`else
            check($sformatf("tbl%0d_en", i), 32'(got_en), 32'h1f);
`endif
        end
        @(negedge clk);

        // ---------------- 127*127: busy/done widths ----------------
        @(negedge clk);
        start  = 1'b1;
        bin    = 14'(127 * 127);
        n_busy = 0;
        n_done = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) n_busy++;
            if (done) n_done++;
        end
        check("max_busy_cycles", 32'(n_busy), 32'd14);
        check("max_done_cycles", 32'(n_done), 32'd1);
        check("max_bcd", 32'(bcd), 32'h16129);

        // ---------------- back-to-back from DONE ----------------
        run_conv(14'd9999, got_b, got_en, lat);
        check("b2b_first_bcd", 32'(got_b), 32'h09999);
        start = 1'b1;               // sampled in the DONE cycle
        bin   = 14'd10;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_bubble_busy", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_latency", 32'(lat), 32'd15);
        check("b2b_second_bcd", 32'(bcd), 32'h00010);
`ifdef PRODUCT_BCD_BLANK_EN
        check("b2b_second_en", 32'(digit_en), 32'h03);
`else
        check("b2b_second_en", 32'(digit_en), 32'h1f);
`endif
        repeat (2) @(negedge clk);

        // ---------------- start while busy is ignored ----------------
        start = 1'b1;
        bin   = 14'd1234;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        bin   = 14'd5678;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        got_b  = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                got_b = bcd;
            end
        end
        check("ignore_done_count", 32'(n_done), 32'd1);
        check("ignore_bcd", 32'(got_b), 32'h01234);

        // ---------------- reset mid-conversion ----------------
        start = 1'b1;
        bin   = 14'd4321;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_bcd", 32'(bcd), 32'h0);
        check("midrst_en", 32'(digit_en), 32'h1f);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_no_done", 32'(n_done), 32'd0);
        check("midrst_bcd_held", 32'(bcd), 32'h0);
        run_conv(14'd42, got_b, got_en, lat);
        check("after_rst_latency", 32'(lat), 32'd15);
        check("after_rst_bcd", 32'(got_b), 32'h00042);

        // ---------------- product sweep (strided) ----------------
        for (int a = 0; a < 128; a += 9) begin
            for (int b = 0; b < 128; b += 11) begin
                exp_q.push_back(model_bcd(a * b));
                run_conv(14'(a * b), got_b, got_en, lat);
                exp_b = exp_q.pop_front();
                check($sformatf("sweep_%0dx%0d_bcd", a, b), 32'(got_b), 32'(exp_b));
                check($sformatf("sweep_%0dx%0d_en", a, b), 32'(got_en), 32'(model_en(exp_b)));
            end
        end
        run_conv(14'(127 * 127), got_b, got_en, lat);
        check("sweep_127x127_bcd", 32'(got_b), 32'(model_bcd(16129)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
